// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- four-digit multiplexed seven-segment scan controller.
//
// Cycles through four digits with a blanking gap before each one to avoid
// ghosting. A new 16-bit display value is held pending and only committed
// at a frame boundary while scanning, or on the next cycle while idle, so a
// frame never shows a mix of old and new digits.
//
// Parameters:
//   DIV_CNT  cycles each digit is lit (>= 2)
//   GAP_CYC  blanking cycles before each digit (>= 1)
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   en          scan enable; 0 blanks the display
//   wr_en       write strobe for wr_data
//   wr_data     four hex nibbles, digit k = wr_data[4k+3:4k]
//   wr_ack      one-cycle pulse when a pending value is committed
//   nib         nibble for the current digit (to the segment decoder)
//   an_n        active-low digit anodes
//   frame_done  one-cycle pulse at each completed four-digit frame
//
// Build option:
//   SEG_LEADING_ZERO_BLANK_EN  when defined, leading zero digits are not lit
//                              (digit 0 always lit; scan timing unchanged).
//
// State table:
//   S_OFF | idle, display blank, pending value commits immediately
//   S_GAP | blanking gap before digit idx, nib already holds its value
//   S_ON  | digit idx lit for DIV_CNT cycles

module seg_scan_ctrl #(
  parameter int unsigned DIV_CNT = 50000,
  parameter int unsigned GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic [3:0]  nib,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX = (DIV_CNT > GAP_CYC) ? DIV_CNT : GAP_CYC;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CNT - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_GAP = 2'd1,
    S_ON  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nib_q, nib_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pending_q, pending_d;
  logic          wr_ack_q, wr_ack_d;
  logic          frame_done_q, frame_done_d;

  logic          commit;
  logic          load_nib;
  logic [15:0]   disp_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      nib_q        <= 4'h0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pending_q    <= 1'b0;
      wr_ack_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      nib_q        <= nib_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      wr_ack_q     <= wr_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    nib_d        = nib_q;
    pend_d       = pend_q;
    pending_d    = pending_q;
    wr_ack_d     = 1'b0;
    frame_done_d = 1'b0;
    commit       = 1'b0;
    load_nib     = 1'b0;

    case (state_q)
      S_OFF: begin
        idx_d  = 2'd0;
        cnt_d  = '0;
        commit = pending_q;
        if (en) begin
          state_d  = S_GAP;
          cnt_d    = GAP_LOAD;
          load_nib = 1'b1;
        end
      end
      S_GAP: begin
        if (!en) begin
          state_d = S_OFF;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_ON;
          cnt_d   = DIV_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ON: begin
        if (!en) begin
          // dropping en on the wrap cycle still suppresses frame_done
          state_d = S_OFF;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = S_GAP;
          idx_d    = idx_q + 2'd1;
          cnt_d    = GAP_LOAD;
          load_nib = 1'b1;
          if (idx_q == 2'd3) begin
            frame_done_d = 1'b1;
            commit       = pending_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase

    // digit 0 of a new frame must already see the freshly committed value
    disp_nxt = commit ? pend_q : disp_q;
    disp_d   = disp_nxt;

    if (commit) begin
      pending_d = 1'b0;
      wr_ack_d  = 1'b1;
    end
    // a write on the commit cycle stays pending for the next boundary
    if (wr_en) begin
      pend_d    = wr_data;
      pending_d = 1'b1;
    end

    if (load_nib) begin
      nib_d = 4'(disp_nxt >> {idx_d, 2'b00});
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic lead_zero;
  assign lead_zero = ((disp_q >> {idx_q, 2'b00}) == 16'h0000) && (idx_q != 2'd0);
`endif

  always_comb begin
    an_n = 4'b1111;
    if (state_q == S_ON) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (!lead_zero) begin
        an_n[idx_q] = 1'b0;
      end
`else
      an_n[idx_q] = 1'b0;
`endif
    end
  end

  assign nib        = nib_q;
  assign wr_ack     = wr_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int DIV = 4;
  localparam int GAP = 2;
  localparam int P   = DIV + GAP;
  localparam int FR  = 4 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic [3:0]  nib;
  logic [3:0]  an_n;
  logic        frame_done;

  seg_scan_ctrl #(.DIV_CNT(DIV), .GAP_CYC(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .nib        (nib),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

  typedef struct {
    int unsigned stamp;
    logic [3:0]  an;
    logic [3:0]  nb;
  } lit_t;

  lit_t        lit_q[$];
  int unsigned ack_q[$];
  int unsigned fd_q[$];

  // reference model: scan position is a single time index within the frame
  bit          m_scan    = 1'b0;
  int          m_t       = 0;
  logic [15:0] m_disp    = 16'h0;
  logic [15:0] m_pend    = 16'h0;
  bit          m_pending = 1'b0;

  function automatic bit blanked(input int dig, input logic [15:0] v);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    return (dig > 0) && ((v >> (4 * dig)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic r, input logic e, input logic w, input logic [15:0] d);
    int unsigned stamp;
    bit commit;
    bit fd;
    int dig;
    int off;
    lit_t ev;
    @(negedge clk);
    rst_n   = r;
    en      = e;
    wr_en   = w;
    wr_data = d;
    stamp   = cyc + 1;
    if (!r) begin
      m_scan = 0; m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_pending = 0;
    end else begin
      commit = 0;
      fd     = 0;
      if (!m_scan) begin
        if (m_pending) commit = 1;
        if (e) begin m_scan = 1; m_t = 0; end
      end else if (!e) begin
        m_scan = 0;
      end else begin
        m_t++;
        if (m_t == FR) begin
          m_t = 0;
          fd  = 1;
          if (m_pending) commit = 1;
        end
      end
      if (commit) begin
        m_disp    = m_pend;
        m_pending = 0;
        ack_q.push_back(stamp);
      end
      if (fd) fd_q.push_back(stamp);
      if (w) begin
        m_pend    = d;
        m_pending = 1;
      end
      if (m_scan) begin
        dig = m_t / P;
        off = m_t % P;
        if (off >= GAP && !blanked(dig, m_disp)) begin
          ev.stamp = stamp;
          ev.an    = ~(4'b0001 << dig);
          ev.nb    = 4'(m_disp >> (4 * dig));
          lit_q.push_back(ev);
        end
      end
    end
  endtask

  task automatic run(input int n, input logic e);
    for (int k = 0; k < n; k++) step(1'b1, e, 1'b0, 16'h0);
  endtask

  task automatic run_until_t(input int t, input int budget);
    int k;
    k = 0;
    while (!(m_scan && m_t == t) && k < budget) begin
      step(1'b1, 1'b1, 1'b0, 16'h0);
      k++;
    end
    checks++;
    if (k >= budget) begin
      failures++;
      $display("FAIL sync_budget target_t=%0d got_t=%0d scan=%0d", t, m_t, m_scan);
    end
  endtask

  // monitor: compares DUT events against the scoreboard queues
  always @(posedge clk) begin
    lit_t ev;
    #1;
    if (mon_on) begin
      while (lit_q.size() > 0 && lit_q[0].stamp < cyc) begin
        checks++; failures++;
        $display("FAIL lit_missing cyc=%0d expected an_n=%b nib=%h", lit_q[0].stamp, lit_q[0].an, lit_q[0].nb);
        void'(lit_q.pop_front());
      end
      if (an_n !== 4'b1111) begin
        checks++;
        if (lit_q.size() == 0 || lit_q[0].stamp != cyc) begin
          failures++;
          $display("FAIL lit_unexpected cyc=%0d an_n=%b nib=%h, required blank", cyc, an_n, nib);
        end else begin
          ev = lit_q.pop_front();
          if (an_n !== ev.an || nib !== ev.nb) begin
            failures++;
            $display("FAIL lit_value cyc=%0d an_n=%b nib=%h, required an_n=%b nib=%h", cyc, an_n, nib, ev.an, ev.nb);
          end
        end
      end

      while (ack_q.size() > 0 && ack_q[0] < cyc) begin
        checks++; failures++;
        $display("FAIL ack_missing expected wr_ack at cyc=%0d", ack_q[0]);
        void'(ack_q.pop_front());
      end
      if (wr_ack !== 1'b0) begin
        checks++;
        if (ack_q.size() == 0 || ack_q[0] != cyc) begin
          failures++;
          $display("FAIL ack_unexpected cyc=%0d wr_ack=%b, required 0", cyc, wr_ack);
        end else begin
          void'(ack_q.pop_front());
        end
      end

      while (fd_q.size() > 0 && fd_q[0] < cyc) begin
        checks++; failures++;
        $display("FAIL frame_done_missing expected at cyc=%0d", fd_q[0]);
        void'(fd_q.pop_front());
      end
      if (frame_done !== 1'b0) begin
        checks++;
        if (fd_q.size() == 0 || fd_q[0] != cyc) begin
          failures++;
          $display("FAIL frame_done_unexpected cyc=%0d frame_done=%b, required 0", cyc, frame_done);
        end else begin
          void'(fd_q.pop_front());
        end
      end
    end
  end

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  initial begin
    int drop;
    logic r, e, w;
    logic [15:0] d;
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_data = 16'h0;

    // reset, with a write in the reset cycle that must be discarded
    step(1'b0, 1'b1, 1'b1, 16'hFFFF);
    mon_on = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    @(posedge clk); #2;
    chk4("reset_an_n", an_n, 4'b1111);
    chk4("reset_nib", nib, 4'h0);
    chk4("reset_wr_ack", {3'b0, wr_ack}, 4'h0);
    chk4("reset_frame_done", {3'b0, frame_done}, 4'h0);
    run(3, 1'b0);

    // plain scan of zero value, several frames
    run(3 * FR + 5, 1'b1);

    // write while idle, then scan it
    run(3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h1234);
    run(4, 1'b0);
    run(FR + 3, 1'b1);

    // mid-frame write: current frame keeps old value
    run_until_t(9, 200);
    step(1'b1, 1'b1, 1'b1, 16'hABCD);
    run(2 * FR, 1'b1);

    // two writes in a frame plus one on the commit cycle
    run_until_t(3, 200);
    step(1'b1, 1'b1, 1'b1, 16'h1111);
    run(4, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h2222);
    run_until_t(FR - 1, 200);
    step(1'b1, 1'b1, 1'b1, 16'h3333);
    run(2 * FR + 2, 1'b1);

    // en dropped during digit 2, then restart
    run_until_t(2 * P + GAP + 1, 200);
    run(3, 1'b0);
    run(FR + 4, 1'b1);

    // leading-zero patterns (blanking only differs in the macro build)
    step(1'b1, 1'b1, 1'b1, 16'h0050);
    run(2 * FR, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h0000);
    run(2 * FR, 1'b1);

    // random traffic
    drop = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(999) != 0);
      if (drop > 0) begin
        drop--;
        e = 1'b0;
      end else if ($urandom_range(199) == 0) begin
        drop = $urandom_range(5, 1);
        e = 1'b0;
      end else begin
        e = 1'b1;
      end
      w = ($urandom_range(9) == 0);
      d = ($urandom_range(3) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
      step(r, e, w, d);
    end

    run(10, 1'b0);
    @(posedge clk); #3;
    checks++;
    if (lit_q.size() + ack_q.size() + fd_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained actual lit=%0d ack=%0d fd=%0d required 0", lit_q.size(), ack_q.size(), fd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
